// File: rtl/frame_buffer_filter.sv
// Frame buffer with a 2-cycle read pipeline and a frame-synchronous colour filter on the read port.
// Optional write counter is enabled by defining FRAME_BUFFER_WR_COUNT_EN.
module frame_buffer_filter #(
    parameter  int AW    = 15,
    parameter  int DEPTH = 19200,
    parameter  int RW    = 1,
    parameter  int GW    = 1,
    parameter  int BW    = 1,
    localparam int DW    = RW + GW + BW
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          wr_en_i,
    input  logic [AW-1:0] wr_addr_i,
    input  logic [DW-1:0] wr_data_i,
    input  logic          rd_en_i,
    input  logic [AW-1:0] rd_addr_i,
    output logic [DW-1:0] rd_data_o,
    output logic          rd_valid_o,
    input  logic [2:0]    filter_sel_i,
    input  logic          frame_sync_i,
    output logic [2:0]    filter_active_o,
    output logic          wr_oob_o,
    output logic [AW:0]   wr_count_o
);

    localparam logic [AW:0]   DEPTH_W = (AW+1)'(DEPTH);
    localparam logic [DW-1:0] R_MASK  = {{RW{1'b1}}, {(GW+BW){1'b0}}};
    localparam logic [DW-1:0] G_MASK  = {{RW{1'b0}}, {GW{1'b1}}, {BW{1'b0}}};
    localparam logic [DW-1:0] B_MASK  = {{(RW+GW){1'b0}}, {BW{1'b1}}};

    function automatic logic [DW-1:0] filter_px(input logic [2:0] mode, input logic [DW-1:0] p);
        logic [DW-1:0] res;
        logic          maj;
        maj = (p[DW-1] & p[BW+GW-1]) | (p[DW-1] & p[BW-1]) | (p[BW+GW-1] & p[BW-1]);
        res = p;
        case (mode)
            3'd1: res = ~p;
            3'd2: res = p & R_MASK;
            3'd3: res = p & G_MASK;
            3'd4: res = p & B_MASK;
            3'd5: res = maj ? '1 : '0;
            3'd6: begin
                // Swap only makes sense when R and B have equal width; otherwise pass through.
                if (RW == BW) begin
                    for (int i = 0; i < RW; i++) begin
                        res[DW-RW+i] = p[i];
                        res[i]       = p[DW-RW+i];
                    end
                end
            end
            default: res = p;
        endcase
        return res;
    endfunction

    logic [DW-1:0] mem [DEPTH];

    logic          wr_inr;
    logic          wr_ok;
    logic          rd_inr;
    logic          wr_oob_q;
    logic [2:0]    filter_active_q;
    logic [DW-1:0] pix_p1_q;
    logic          inr_p1_q;
    logic          vld_p1_q;
    logic [DW-1:0] rd_data_p2_q;
    logic          vld_p2_q;

    assign wr_inr = ({1'b0, wr_addr_i} < DEPTH_W);
    assign rd_inr = ({1'b0, rd_addr_i} < DEPTH_W);
    assign wr_ok  = wr_en_i & wr_inr & ~rst_i;

    always_ff @(posedge clk_i) begin
        if (wr_ok) begin
            mem[wr_addr_i] <= wr_data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_oob_q        <= 1'b0;
            filter_active_q <= 3'd0;
        end else begin
            if (wr_en_i && !wr_inr) begin
                wr_oob_q <= 1'b1;
            end
            if (frame_sync_i) begin
                filter_active_q <= filter_sel_i;
            end
        end
    end

    // Stage 1: RAM read (old contents on a same-address write), in-range flag, valid
    always_ff @(posedge clk_i) begin
        if (rd_en_i) begin
            pix_p1_q <= mem[rd_addr_i];
            inr_p1_q <= rd_inr;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            vld_p1_q <= 1'b0;
        end else begin
            vld_p1_q <= rd_en_i;
        end
    end

    // Stage 2: filter with the mode latched before this cycle's frame_sync
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            vld_p2_q     <= 1'b0;
            rd_data_p2_q <= '0;
        end else begin
            vld_p2_q <= vld_p1_q;
            if (vld_p1_q) begin
                rd_data_p2_q <= inr_p1_q ? filter_px(filter_active_q, pix_p1_q) : '0;
            end
        end
    end

`ifdef FRAME_BUFFER_WR_COUNT_EN
    logic [AW:0] wr_count_q;
    logic [AW:0] wr_count_d;

    always_comb begin
        wr_count_d = wr_count_q;
        if (frame_sync_i) begin
            wr_count_d = wr_ok ? (AW+1)'(1) : '0;
        end else if (wr_ok && (wr_count_q != '1)) begin
            wr_count_d = wr_count_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_count_q <= '0;
        end else begin
            wr_count_q <= wr_count_d;
        end
    end

    assign wr_count_o = wr_count_q;
`else
    assign wr_count_o = '0;
`endif

    assign rd_data_o       = rd_data_p2_q;
    assign rd_valid_o      = vld_p2_q;
    assign filter_active_o = filter_active_q;
    assign wr_oob_o        = wr_oob_q;

endmodule

// File: tb/tb_frame_buffer_filter.sv
// Directed self-checking bench for frame_buffer_filter (1-bit fields plus a 2-bit-field instance).
module tb_frame_buffer_filter;

    localparam int AW = 15;

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [2:0]    wr_data;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [2:0]    rd_data;
    logic          rd_valid;
    logic [2:0]    filter_sel;
    logic          frame_sync;
    logic [2:0]    filter_active;
    logic          wr_oob;
    logic [AW:0]   wr_count;

    logic          wr_en2;
    logic [AW-1:0] wr_addr2;
    logic [5:0]    wr_data2;
    logic          rd_en2;
    logic [AW-1:0] rd_addr2;
    logic [5:0]    rd_data2;
    logic          rd_valid2;
    logic [2:0]    filter_active2;
    logic          wr_oob2;
    logic [AW:0]   wr_count2;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    frame_buffer_filter #(.AW(AW), .DEPTH(19200), .RW(1), .GW(1), .BW(1)) dut (
        .clk_i(clk), .rst_i(rst),
        .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
        .rd_en_i(rd_en), .rd_addr_i(rd_addr),
        .rd_data_o(rd_data), .rd_valid_o(rd_valid),
        .filter_sel_i(filter_sel), .frame_sync_i(frame_sync),
        .filter_active_o(filter_active), .wr_oob_o(wr_oob), .wr_count_o(wr_count)
    );

    frame_buffer_filter #(.AW(AW), .DEPTH(19200), .RW(2), .GW(2), .BW(2)) dut2 (
        .clk_i(clk), .rst_i(rst),
        .wr_en_i(wr_en2), .wr_addr_i(wr_addr2), .wr_data_i(wr_data2),
        .rd_en_i(rd_en2), .rd_addr_i(rd_addr2),
        .rd_data_o(rd_data2), .rd_valid_o(rd_valid2),
        .filter_sel_i(filter_sel), .frame_sync_i(frame_sync),
        .filter_active_o(filter_active2), .wr_oob_o(wr_oob2), .wr_count_o(wr_count2)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [2:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        step();
        wr_en = 1'b0;
    endtask

    task automatic set_filter(input logic [2:0] m);
        filter_sel = m; frame_sync = 1'b1;
        step();
        frame_sync = 1'b0;
    endtask

    // Read with latency check: no valid after one cycle, valid and data after two.
    task automatic rd(input string tag, input logic [AW-1:0] a, input logic [2:0] exp);
        rd_en = 1'b1; rd_addr = a;
        step();
        rd_en = 1'b0;
        chk({tag, "_lat1"}, 32'(rd_valid), 32'd0);
        step();
        chk({tag, "_vld"}, 32'(rd_valid), 32'd1);
        chk({tag, "_data"}, 32'(rd_data), 32'(exp));
    endtask

    initial begin
        rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        rd_en = 1'b0; rd_addr = '0; filter_sel = 3'd0; frame_sync = 1'b0;
        wr_en2 = 1'b0; wr_addr2 = '0; wr_data2 = '0; rd_en2 = 1'b0; rd_addr2 = '0;
        step();
        step();
        chk("rst_rd_data", 32'(rd_data), 32'd0);
        chk("rst_rd_valid", 32'(rd_valid), 32'd0);
        chk("rst_filter_active", 32'(filter_active), 32'd0);
        chk("rst_wr_oob", 32'(wr_oob), 32'd0);
        chk("rst_wr_count", 32'(wr_count), 32'd0);
        rst = 1'b0;

        wr(5, 3'b101);
        rd("pass5", 5, 3'b101);
        step();
        chk("hold_vld", 32'(rd_valid), 32'd0);
        chk("hold_data", 32'(rd_data), 32'b101);

        filter_sel = 3'd1;
        step();
        chk("nosync_fa", 32'(filter_active), 32'd0);
        rd("nosync5", 5, 3'b101);
        set_filter(3'd1);
        chk("sync_fa", 32'(filter_active), 32'd1);
        rd("inv5", 5, 3'b010);

        wr(1, 3'b110);
        wr(2, 3'b100);
        wr(3, 3'b111);
        wr(0, 3'b010);
        wr(19199, 3'b011);
        set_filter(3'd5);
        rd("mono110", 1, 3'b111);
        rd("mono100", 2, 3'b000);
        set_filter(3'd2);
        rd("red5", 5, 3'b100);
        set_filter(3'd3);
        rd("grn7", 3, 3'b010);
        set_filter(3'd4);
        rd("blu7", 3, 3'b001);
        set_filter(3'd6);
        rd("swap6", 1, 3'b011);
        set_filter(3'd7);
        rd("rsv6", 1, 3'b110);

        // Frame sync while a pixel sits in stage 2 must not affect that pixel.
        set_filter(3'd0);
        rd_en = 1'b1; rd_addr = 5;
        step();
        rd_en = 1'b0; filter_sel = 3'd1; frame_sync = 1'b1;
        step();
        frame_sync = 1'b0;
        chk("sync_edge_data", 32'(rd_data), 32'b101);
        set_filter(3'd0);

        wr(19200, 3'b111);
        chk("oob_flag", 32'(wr_oob), 32'd1);
        rd("oob_ram0", 0, 3'b010);
        rd("oob_ramlast", 19199, 3'b011);
        rd("oob_rd", 20000, 3'b000);
        set_filter(3'd1);
        rd("oob_rd_inv", 20000, 3'b000);
        set_filter(3'd0);
        chk("oob_sticky", 32'(wr_oob), 32'd1);

        wr(7, 3'b001);
        wr_en = 1'b1; wr_addr = 7; wr_data = 3'b110;
        rd_en = 1'b1; rd_addr = 7;
        step();
        wr_en = 1'b0; rd_en = 1'b0;
        step();
        chk("coll_vld", 32'(rd_valid), 32'd1);
        chk("coll_old", 32'(rd_data), 32'b001);
        rd("coll_new", 7, 3'b110);

        rd_en = 1'b1; rd_addr = 1;
        step();
        rd_addr = 2;
        step();
        chk("b2b_0", 32'({rd_valid, rd_data}), 32'b1110);
        rd_addr = 3;
        step();
        chk("b2b_1", 32'({rd_valid, rd_data}), 32'b1100);
        rd_en = 1'b0;
        step();
        chk("b2b_2", 32'({rd_valid, rd_data}), 32'b1111);
        step();
        chk("b2b_end", 32'(rd_valid), 32'd0);

        // Reset one cycle into a read, with a write to addr 5 that must be ignored.
        set_filter(3'd3);
        rd_en = 1'b1; rd_addr = 5;
        step();
        rd_en = 1'b0; rst = 1'b1;
        wr_en = 1'b1; wr_addr = 5; wr_data = 3'b000;
        step();
        wr_en = 1'b0; rst = 1'b0;
        chk("rstmid_vld0", 32'(rd_valid), 32'd0);
        chk("rstmid_data", 32'(rd_data), 32'd0);
        chk("rstmid_fa", 32'(filter_active), 32'd0);
        chk("rstmid_oob", 32'(wr_oob), 32'd0);
        step();
        chk("rstmid_vld1", 32'(rd_valid), 32'd0);
        rd("rst_wr_ignored", 5, 3'b101);

        for (int i = 0; i < 10; i++) wr(AW'(100 + i), 3'(i));
        wr(20000, 3'b111);
`ifdef FRAME_BUFFER_WR_COUNT_EN
        chk("wrcnt10", 32'(wr_count), 32'd10);
`else
        chk("wrcnt_tied", 32'(wr_count), 32'd0);
`endif
        frame_sync = 1'b1; filter_sel = 3'd0;
        wr(110, 3'b011);
        frame_sync = 1'b0;
`ifdef FRAME_BUFFER_WR_COUNT_EN
        chk("wrcnt_sync", 32'(wr_count), 32'd1);
`else
        chk("wrcnt_sync_tied", 32'(wr_count), 32'd0);
`endif
        rd("stream_104", 104, 3'd4);

        wr_en2 = 1'b1; wr_addr2 = 9; wr_data2 = 6'b10_10_01;
        step();
        wr_en2 = 1'b0;
        set_filter(3'd5);
        rd_en2 = 1'b1; rd_addr2 = 9;
        step();
        rd_en2 = 1'b0;
        step();
        chk("w2_vld", 32'(rd_valid2), 32'd1);
        chk("w2_mono", 32'(rd_data2), 32'b111111);
        set_filter(3'd6);
        rd_en2 = 1'b1;
        step();
        rd_en2 = 1'b0;
        step();
        chk("w2_swap", 32'(rd_data2), 32'b01_10_10);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
